// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode constants, field widths and fetch state encoding.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int OPC_W = OPC_HI - OPC_LO + 1;
  localparam logic [OPC_W-1:0] OP_NOP = 5'd0;
  localparam logic [OPC_W-1:0] OP_JMP = 5'd16;
  localparam logic [OPC_W-1:0] OP_HLT = 5'd31;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} fetch_state_e;
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with async reset, wrapping increment and parallel load.
module pc_reg import cpu_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  assign pc_d = load_i ? load_val_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;
  assign pc_o = pc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/ISSUE/HALT instruction fetcher feeding the control unit.
// Define FETCH_JUMP_EN to resolve JMP inside FETCH instead of issuing it.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  adress,
  output logic               mem_req,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] op,
  output logic               op_valid,
  input  logic               op_ready,
  output logic               halted
);
  fetch_state_e state_q, state_d;
  logic [INSTR_W-1:0] op_q, op_d;
  logic pc_inc, pc_load;
  logic [ADDR_W-1:0] pc_val;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .inc_i(pc_inc), .load_i(pc_load),
    .load_val_i(pc_val), .pc_o(adress)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
    end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    pc_inc = 1'b0;
    pc_load = 1'b0;
    pc_val = RESET_PC;
    case (state_q)
      S_IDLE, S_HALT: if (start) begin
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: if (mem_ack) begin
`ifdef FETCH_JUMP_EN
        if (opcode_of(mem_data) == OP_JMP) begin
          pc_load = 1'b1;
          pc_val = mem_data[26:19];
        end else
`endif
        begin
          op_d = mem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (op_ready) begin
        pc_inc = opcode_of(op_q) != OP_HLT;
        state_d = pc_inc ? S_FETCH : S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign mem_req = state_q == S_FETCH;
  assign op_valid = state_q == S_ISSUE;
  assign halted = state_q == S_HALT;
  // Decoder must see NOP whenever nothing is live.
  assign op = op_valid ? op_q : '0;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, start address loaded at reset and on restart.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begins fetching from IDLE or HALT.
REQ-005 SHALL have port adress  output  8  instruction memory word address (program counter).
REQ-006 SHALL have port mem_req  output  1  memory read request; held until mem_ack.
REQ-007 SHALL have port mem_data  input  32  instruction word; valid when mem_ack=1.
REQ-008 SHALL have port mem_ack  input  1  read completion; may assert in the same cycle as mem_req.
REQ-009 SHALL have port op  output  32  instruction to control unit; bits [31:27] opcode.
REQ-010 SHALL have port op_valid  output  1  op holds a live instruction.
REQ-011 SHALL have port op_ready  input  1  control unit accepts op this cycle.
REQ-012 SHALL have port halted  output  1  HLT retired; fetch stopped.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, ISSUE, HALT; reset state IDLE.
REQ-014 IDLE: start=1 -> FETCH next cycle; adress=RESET_PC.
REQ-015 FETCH: mem_req=1, adress=PC; on mem_ack=1 latch mem_data into op register, -> ISSUE next cycle; mem_req drops in that same next cycle.
REQ-016 ISSUE: op_valid=1, op stable until op_valid&&op_ready; on handshake PC <= PC+1 (8-bit, 8'hFF wraps to 8'h00), -> FETCH.
REQ-017 Opcode 31 (HLT) on handshake: PC not incremented, -> HALT, halted=1 from the next cycle.
REQ-018 HALT: mem_req=0, op_valid=0; start=1 -> PC=RESET_PC, halted=0, -> FETCH.
REQ-019 Whenever op_valid=0, op SHALL be driven 32'h0 (opcode 0, NOP), so the combinational decoder sees NOP.
REQ-020 Opcode 0 SHALL be issued like any other instruction (not skipped).
REQ-021 start SHALL be ignored in FETCH and ISSUE; mem_ack SHALL be ignored when mem_req=0.
REQ-022 Best-case throughput: one instruction per 2 cycles (FETCH with same-cycle ack, ISSUE with op_ready=1).

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, PC=RESET_PC, adress=RESET_PC, mem_req=0, op=0, op_valid=0, halted=0, including mid-FETCH or mid-ISSUE; the in-flight read is abandoned.
REQ-024 First start SHALL be honoured on the first rising edge with rst_n=1.

Configuration
REQ-025 Macro FETCH_JUMP_EN: when defined, opcode 16 (JMP) latched in FETCH SHALL NOT be issued; state -> FETCH with PC <= op[26:19], op_valid stays 0, and the jump costs one cycle.
REQ-026 Without FETCH_JUMP_EN: opcode 16 SHALL be issued as a normal instruction and PC increments.

Structure
REQ-027 Shared package cpu_pkg SHALL hold opcode constants (OP_NOP=0, OP_JMP=16, OP_HLT=31), opcode field range [31:27], address width 8, instruction width 32, and the fetch state enumeration.
REQ-028 One sub-module, pc_reg, is natural: 8-bit program counter with async reset to RESET_PC, increment-with-wrap, and parallel load (restart/jump).

Verification
REQ-029 Reset, start, memory returning 0x10000000 at addr 0 with same-cycle ack, op_ready=1 -> mem_req at cycle 1, op=0x10000000/op_valid at cycle 2, adress=1 at cycle 3.
REQ-030 op_ready held 0 for 5 cycles in ISSUE -> op and op_valid stable for all 5, PC unchanged, no mem_req.
REQ-031 PC=8'hFF, non-HLT instruction handshaken -> next FETCH adress=8'h00.
REQ-032 HLT word 0xF8000000 at addr 3 -> issued once, halted=1 the cycle after handshake, adress stays 3; start -> adress=RESET_PC, halted=0.
REQ-033 rst_n pulled low during FETCH with mem_ack pending -> mem_req=0, op=0, adress=RESET_PC without waiting for a clock edge; a subsequent mem_ack is ignored.
REQ-034 With FETCH_JUMP_EN, word 0x80280000 (JMP to 5) at addr 2 -> op_valid never rises for it, next mem_req has adress=5; without the macro -> issued, next adress=3.
